// File: rtl/axis_spm_dac_tx_if.sv
// Four parallel Q31 AXI-stream control samples (X, Y, Z, Bias) sharing one
// ready strobe; channel k is lane k of tdata/tvalid.
interface axis_spm_dac_tx_if #(
  parameter int SAXIS_TDATA_WIDTH = 32
);
  logic [3:0][SAXIS_TDATA_WIDTH-1:0] tdata;
  logic [3:0]                        tvalid;
  logic                              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_spm_dac_tx.sv
// Four-channel 24-bit SPI DAC transmitter: samples all streams at once, rounds
// and saturates to DAC codes, shifts them out in lockstep, then pulses LDAC.
module axis_spm_dac_tx #(
  parameter int         SAXIS_TDATA_WIDTH = 32,
  parameter int         DAC_BITS          = 20,
  parameter logic [3:0] CMD               = 4'b0001,
  parameter int         SCLK_HALF         = 2,
  parameter int         LDAC_W            = 4,
  parameter bit         OFFSET_BINARY     = 1'b0
) (
  input  logic                a_clk,
  input  logic                a_resetn,
  axis_spm_dac_tx_if.slave    s_axis,
  input  logic                enable,
  output logic                dac_sclk,
  output logic                dac_cs_n,
  output logic [3:0]          dac_sdi,
  output logic                dac_ldac_n,
  output logic                busy,
  output logic [31:0]         frame_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_LDAC  = 3'd4;

  localparam logic [15:0] HALF     = 16'(SCLK_HALF);
  localparam logic [15:0] BIT_END  = 16'(2 * SCLK_HALF - 1);
  localparam logic [15:0] HOLD_END = 16'd1;
  localparam logic [15:0] LDAC_END = 16'(LDAC_W - 1);

  typedef logic [SAXIS_TDATA_WIDTH-1:0] sample_t;

  logic [2:0]        state;
  logic [15:0]       cnt;
  logic [4:0]        bit_idx;
  logic [3:0][23:0]  shreg;
  logic [3:0][23:0]  word;
  sample_t [3:0]     held;
  sample_t [3:0]     sample_next;
  logic              tready_q;

  // Round-half-up to DAC_BITS, clamping the single overflow case at +max.
  function automatic logic [23:0] frame_word(input sample_t s);
    logic [DAC_BITS-1:0] t;
    logic [DAC_BITS-1:0] code;
    logic [DAC_BITS-1:0] max_pos;
    logic                r;
    t       = s[SAXIS_TDATA_WIDTH-1 -: DAC_BITS];
    r       = s[SAXIS_TDATA_WIDTH-1-DAC_BITS];
    max_pos = {1'b0, {(DAC_BITS-1){1'b1}}};
    code    = (t == max_pos && r) ? max_pos : t + DAC_BITS'(r);
    if (OFFSET_BINARY) code[DAC_BITS-1] = ~code[DAC_BITS-1];
    return {CMD, 20'(code) << (20 - DAC_BITS)};
  endfunction

  // NOTE: combinational block assigns every output on every path, so no latch.
  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      sample_next[ch] = s_axis.tvalid[ch] ? s_axis.tdata[ch] : held[ch];
      word[ch]        = frame_word(sample_next[ch]);
    end
  end

  assign s_axis.tready = tready_q;

  // NOTE: state uses non-blocking assignments so every register updates from
  // pre-edge values, independent of statement order.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      held        <= '0;
      tready_q    <= 1'b0;
      dac_sclk    <= 1'b0;
      dac_cs_n    <= 1'b1;
      dac_sdi     <= '0;
      dac_ldac_n  <= 1'b1;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      tready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_LOAD;
            tready_q <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int ch = 0; ch < 4; ch++) begin
            held[ch]    <= sample_next[ch];
            shreg[ch]   <= word[ch] << 1;
            dac_sdi[ch] <= word[ch][23];
          end
          dac_cs_n <= 1'b0;
          dac_sclk <= 1'b0;
          cnt      <= '0;
          bit_idx  <= 5'd23;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == BIT_END) begin
            cnt      <= '0;
            dac_sclk <= 1'b0;
            if (bit_idx == 5'd0) begin
              state    <= S_HOLD;
              dac_cs_n <= 1'b1;
              dac_sdi  <= '0;
            end else begin
              bit_idx <= bit_idx - 5'd1;
              for (int ch = 0; ch < 4; ch++) begin
                dac_sdi[ch] <= shreg[ch][23];
                shreg[ch]   <= shreg[ch] << 1;
              end
            end
          end else begin
            cnt      <= cnt + 16'd1;
            dac_sclk <= (cnt + 16'd1 >= HALF);
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_END) begin
            cnt        <= '0;
            state      <= S_LDAC;
            dac_ldac_n <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LDAC: begin
          if (cnt == LDAC_END) begin
            cnt         <= '0;
            state       <= S_IDLE;
            dac_ldac_n  <= 1'b1;
            busy        <= 1'b0;
            frame_count <= frame_count + 32'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_spm_dac_tx.sv
// Directed bench for axis_spm_dac_tx: decodes the SPI bus and checks codes,
// framing, hold-on-invalid, enable drop and mid-frame reset.
module tb_axis_spm_dac_tx;

  logic        a_clk = 1'b0;
  logic        a_resetn;
  logic        enable;
  logic        dac_sclk;
  logic        dac_cs_n;
  logic [3:0]  dac_sdi;
  logic        dac_ldac_n;
  logic        busy;
  logic [31:0] frame_count;

  axis_spm_dac_tx_if #(.SAXIS_TDATA_WIDTH(32)) s_axis ();

  axis_spm_dac_tx dut (
    .a_clk       (a_clk),
    .a_resetn    (a_resetn),
    .s_axis      (s_axis.slave),
    .enable      (enable),
    .dac_sclk    (dac_sclk),
    .dac_cs_n    (dac_cs_n),
    .dac_sdi     (dac_sdi),
    .dac_ldac_n  (dac_ldac_n),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 a_clk = ~a_clk;

  // Bus decoder: totals only grow; steps compare deltas against snapshots.
  logic [23:0] rx [4];
  int          cyc = 0, sclk_rises = 0, cs_low = 0, ldac_low = 0, cs_falls = 0;
  int          t_cs_rise = 0, t_ldac_fall = 0, t_fc_last = 0, t_fc_prev = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_ldac = 1'b1;
  logic [31:0] prev_fc = '0;

  initial for (int k = 0; k < 4; k++) rx[k] = '0;

  always @(posedge a_clk) begin
    cyc       <= cyc + 1;
    prev_sclk <= dac_sclk;
    prev_cs   <= dac_cs_n;
    prev_ldac <= dac_ldac_n;
    prev_fc   <= frame_count;
    if (dac_sclk && !prev_sclk && !dac_cs_n) begin
      sclk_rises <= sclk_rises + 1;
      for (int k = 0; k < 4; k++) rx[k] <= {rx[k][22:0], dac_sdi[k]};
    end
    if (!dac_cs_n) cs_low <= cs_low + 1;
    if (!dac_ldac_n) ldac_low <= ldac_low + 1;
    if (!dac_cs_n && prev_cs) cs_falls <= cs_falls + 1;
    if (dac_cs_n && !prev_cs) t_cs_rise <= cyc;
    if (!dac_ldac_n && prev_ldac) t_ldac_fall <= cyc;
    if (frame_count != prev_fc) begin
      t_fc_prev <= t_fc_last;
      t_fc_last <= cyc;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge a_clk);
    #1;
  endtask

  task automatic wait_fc(input logic [31:0] target);
    int n = 0;
    while (frame_count !== target && n < 400) begin step(); n++; end
    check("wait_frame_count", frame_count, target);
  endtask

  task automatic wait_tready();
    int n = 0;
    while (s_axis.tready !== 1'b1 && n < 400) begin step(); n++; end
    check("wait_tready", 32'(s_axis.tready), 32'd1);
  endtask

  task automatic wait_rises(input int base, input int delta);
    int n = 0;
    while (sclk_rises - base < delta && n < 400) begin step(); n++; end
    check("wait_sclk_rises", 32'(sclk_rises - base >= delta), 32'd1);
  endtask

  int base_rises, base_cs, base_ldac, base_falls;

  initial begin
    a_resetn      = 1'b0;
    enable        = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tvalid = '0;
    #12;
    // Reset state
    check("rst_sclk",  32'(dac_sclk),      32'd0);
    check("rst_cs_n",  32'(dac_cs_n),      32'd1);
    check("rst_sdi",   32'(dac_sdi),       32'd0);
    check("rst_ldac",  32'(dac_ldac_n),    32'd1);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_tready",32'(s_axis.tready), 32'd0);
    check("rst_fc",    frame_count,        32'd0);

    // Round and saturate, plus protocol timing
    step();
    a_resetn         = 1'b1;
    s_axis.tdata[0]  = 32'h7FFF_FFFF;
    s_axis.tdata[1]  = 32'h0000_0800;
    s_axis.tdata[2]  = 32'h8000_0000;
    s_axis.tdata[3]  = 32'hFFFF_F7FF;
    s_axis.tvalid    = 4'b1111;
    enable           = 1'b1;
    base_rises = sclk_rises; base_cs = cs_low; base_ldac = ldac_low;
    wait_tready();
    check("load_busy", 32'(busy),     32'd1);
    check("load_cs_n", 32'(dac_cs_n), 32'd1);
    step();
    check("shift0_cs_n",   32'(dac_cs_n),      32'd0);
    check("shift0_tready", 32'(s_axis.tready), 32'd0);
    check("shift0_sclk",   32'(dac_sclk),      32'd0);
    wait_fc(32'd1);
    check("word_ch1", 32'(rx[0]), 32'h17FFFF);
    check("word_ch2", 32'(rx[1]), 32'h100001);
    check("word_ch3", 32'(rx[2]), 32'h180000);
    check("word_ch4", 32'(rx[3]), 32'h1FFFFF);
    check("sclk_rises_24", 32'(sclk_rises - base_rises), 32'd24);
    check("cs_low_96",     32'(cs_low - base_cs),        32'd96);
    check("ldac_low_4",    32'(ldac_low - base_ldac),    32'd4);
    check("ldac_after_cs", 32'(t_ldac_fall - t_cs_rise), 32'd2);
    wait_fc(32'd2);
    step();
    check("frame_period", 32'(t_fc_last - t_fc_prev), 32'd104);

    // Hold on invalid: frame 3 loads channel 2, frame 4 leaves it invalid
    s_axis.tdata[1] = 32'h4000_0000;
    wait_fc(32'd3);
    check("ch2_loaded", 32'(rx[1]), 32'h140000);
    s_axis.tdata[0]  = 32'h0000_0000;
    s_axis.tdata[1]  = 32'h1234_5678;
    s_axis.tdata[2]  = 32'hFFFF_F800;
    s_axis.tdata[3]  = 32'h0000_0FFF;
    s_axis.tvalid    = 4'b1101;
    wait_fc(32'd4);
    check("zero_ch1",   32'(rx[0]), 32'h100000);
    check("ch2_held",   32'(rx[1]), 32'h140000);
    check("round_to_0", 32'(rx[2]), 32'h100000);
    check("round_up_1", 32'(rx[3]), 32'h100001);

    // Enable drop mid-frame
    base_rises = sclk_rises; base_ldac = ldac_low;
    wait_rises(base_rises, 10);
    enable = 1'b0;
    wait_fc(32'd5);
    check("drop_rises_24", 32'(sclk_rises - base_rises), 32'd24);
    check("drop_ldac_4",   32'(ldac_low - base_ldac),    32'd4);
    base_falls = cs_falls;
    repeat (300) step();
    check("drop_no_cs_fall", 32'(cs_falls - base_falls), 32'd0);
    check("drop_fc_stays",   frame_count,                32'd5);
    check("drop_idle_busy",  32'(busy),                  32'd0);

    // Reset mid-SHIFT
    enable = 1'b1;
    base_rises = sclk_rises; base_ldac = ldac_low;
    wait_rises(base_rises, 12);
    a_resetn = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(dac_cs_n),   32'd1);
    check("mid_rst_sclk", 32'(dac_sclk),   32'd0);
    check("mid_rst_ldac", 32'(dac_ldac_n), 32'd1);
    check("mid_rst_sdi",  32'(dac_sdi),    32'd0);
    check("mid_rst_busy", 32'(busy),       32'd0);
    check("mid_rst_fc",   frame_count,     32'd0);
    s_axis.tvalid = 4'b0000;
    repeat (3) step();
    a_resetn = 1'b1;
    wait_fc(32'd1);
    check("post_rst_ch1", 32'(rx[0]), 32'h100000);
    check("post_rst_ch2", 32'(rx[1]), 32'h100000);
    check("post_rst_ch3", 32'(rx[2]), 32'h100000);
    check("post_rst_ch4", 32'(rx[3]), 32'h100000);
    check("aborted_no_ldac", 32'(ldac_low - base_ldac), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
